// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing shared by the timing generator and the overlay blocks.
// Overlays import this package for H_ACTIVE / V_ACTIVE so their geometry tracks the generator.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are half-open: [START, END).
    localparam int HSYNC_START = H_ACTIVE + H_FP;
    localparam int HSYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VSYNC_START = V_ACTIVE + V_FP;
    localparam int VSYNC_END   = V_ACTIVE + V_FP + V_SYNC;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: one pixel per clock, x/y counters plus
// registered sync, blanking, line/frame pulses and a per-frame animation counter.
module vga_timing_gen #(
    parameter int   H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP        = vga_timing_pkg::H_FP,
    parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int   H_BP        = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP        = vga_timing_pkg::V_FP,
    parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int   V_BP        = vga_timing_pkg::V_BP,
    parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 10-bit counters cover at most 1024 positions per axis.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
        end
    endgenerate

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);

    // Window bounds can reach 1024, so compare in 11 bits.
    localparam logic [10:0] H_ACT_W    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START_W = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_W   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START_W = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END_W   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  x_nxt;
    logic [9:0]  y_nxt;
    logic [10:0] x_nxt_w;
    logic [10:0] y_nxt_w;
    logic        hs_window;
    logic        vs_window;

    // y only moves together with an x wrap.
    always_comb begin
        x_nxt = x + 10'd1;
        y_nxt = y;
        if (x == X_LAST) begin
            x_nxt = '0;
            y_nxt = (y == Y_LAST) ? '0 : y + 10'd1;
        end
    end

    assign x_nxt_w   = {1'b0, x_nxt};
    assign y_nxt_w   = {1'b0, y_nxt};
    assign hs_window = (x_nxt_w >= HS_START_W) && (x_nxt_w < HS_END_W);
    assign vs_window = (y_nxt_w >= VS_START_W) && (y_nxt_w < VS_END_W);

    // Flags are derived from the next coordinate so each one lines up with the x/y it accompanies.
    // Reset parks the raster on its last blanking pixel, so the first released edge lands on (0,0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= hs_window ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= vs_window ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            display_on  <= (x_nxt_w < H_ACT_W) && (y_nxt_w < V_ACT_W);
            line_start  <= (x_nxt == 10'd0);
            frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
            // Stepping at the first blank line keeps the count stable over every visible pixel.
            if (x_nxt == 10'd0 && y_nxt_w == V_ACT_W) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken-raster instance for multi-frame behaviour and a
// default 640x480 instance for reset state and first-line timing.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;

    // Small raster: H 4+2+2+2 = 10, V 4+1+2+1 = 8, 80 clocks per frame.
    logic [9:0] s_x, s_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [7:0] s_fc;

    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [7:0] d_fc;

    logic [32:0] obs_s;
    logic [32:0] obs_d;

    int checks;
    int failures;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE(1'b0)
    ) dut_small (
        .clk(clk), .rst_n(rst_n),
        .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_de), .line_start(s_ls), .frame_start(s_fs),
        .frame_count(s_fc)
    );

    vga_timing_gen dut_vga (
        .clk(clk), .rst_n(rst_n),
        .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_de), .line_start(d_ls), .frame_start(d_fs),
        .frame_count(d_fc)
    );

    assign obs_s = {s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs, s_fc};
    assign obs_d = {d_x, d_y, d_hs, d_vs, d_de, d_ls, d_fs, d_fc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } vec_t;

    localparam logic [32:0] D_RESET = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    localparam logic [32:0] S_RESET = {10'd9,   10'd7,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    localparam int          END_T   = 257 * 80 + 26;

    // Closed-form expectation for the small raster, t clocks after the (0,0) edge.
    function automatic logic [32:0] expectS(input int t);
        int xx, yy, fr, fc;
        logic hs, vs, de, ls, fs;
        xx = t % 10;
        yy = (t / 10) % 8;
        fr = t / 80;
        fc = ((t % 80) >= 40) ? fr + 1 : fr;
        hs = (xx >= 6 && xx < 8) ? 1'b0 : 1'b1;
        vs = (yy >= 5 && yy < 7) ? 1'b0 : 1'b1;
        de = (xx < 4) && (yy < 4);
        ls = (xx == 0);
        fs = (xx == 0) && (yy == 0);
        return {10'(xx), 10'(yy), hs, vs, de, ls, fs, 8'(fc % 256)};
    endfunction

    function automatic logic [32:0] expectD(input int t);
        int xx, yy, fr, fc;
        logic hs, vs, de, ls, fs;
        xx = t % 800;
        yy = (t / 800) % 525;
        fr = t / 420000;
        fc = ((t % 420000) >= 384000) ? fr + 1 : fr;
        hs = (xx >= 656 && xx < 752) ? 1'b0 : 1'b1;
        vs = (yy >= 490 && yy < 492) ? 1'b0 : 1'b1;
        de = (xx < 640) && (yy < 480);
        ls = (xx == 0);
        fs = (xx == 0) && (yy == 0);
        return {10'(xx), 10'(yy), hs, vs, de, ls, fs, 8'(fc % 256)};
    endfunction

    task automatic applyStimulus(input logic r);
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int t,
                               input logic [32:0] actual, input logic [32:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s t=%0d actual=%h expected=%h", name, t, actual, expected);
        end
    endtask

    vec_t tbl [13];

    initial begin
        int last_fs, last_ls, hs_low, hs_first, vs_low;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;

        tbl[0]  = '{1'b0, 10'd9, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 10'd9, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 10'd4, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 10'd5, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 10'd6, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 10'd7, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 10'd8, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b1, 10'd9, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[12] = '{1'b1, 10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};

        // Three reset clocks here plus two table rows gives five in total.
        repeat (3) applyStimulus(1'b0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].rst_n);
            checkOutput("small_vec", i, obs_s, {tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs,
                                                tbl[i].de, tbl[i].ls, tbl[i].fs, tbl[i].fc});
            if (!tbl[i].rst_n)
                checkOutput("vga_reset", i, obs_d, D_RESET);
            else
                checkOutput("vga_model", i - 2, obs_d, expectD(i - 2));
        end

        last_fs  = 0;
        last_ls  = 0;
        hs_low   = 0;
        hs_first = -1;
        vs_low   = 0;

        // Free-run past 257 small frames, ending inside an hsync pulse at small (6,2).
        for (int t = 11; t <= END_T; t++) begin
            applyStimulus(1'b1);
            checkOutput("small_model", t, obs_s, expectS(t));
            checkOutput("vga_model", t, obs_d, expectD(t));

            if (s_fs) begin
                checkOutput("small_fs_period", t, 33'(t - last_fs), 33'd80);
                last_fs = t;
            end
            if (d_ls) begin
                checkOutput("vga_ls_period", t, 33'(t - last_ls), 33'd800);
                last_ls = t;
            end
            if (t < 800 && !d_hs) begin
                if (hs_first < 0) hs_first = t;
                hs_low++;
            end
            if (t == 800) begin
                checkOutput("vga_hs_len", t, 33'(hs_low), 33'd96);
                checkOutput("vga_hs_first", t, 33'(hs_first), 33'd656);
            end
            if (!s_vs) vs_low++;
            if (t % 80 == 79) begin
                checkOutput("small_vs_len", t, 33'(vs_low), 33'd20);
                vs_low = 0;
            end
            if (t == 255 * 80 + 39) checkOutput("fc_before_wrap", t, 33'(s_fc), 33'd255);
            if (t == 255 * 80 + 40) checkOutput("fc_wrap", t, 33'(s_fc), 33'd0);
        end

        // One-clock reset mid-frame, mid-hsync: outputs snap to reset values, no pulse carries over.
        applyStimulus(1'b0);
        checkOutput("small_midreset", END_T + 1, obs_s, S_RESET);
        checkOutput("vga_midreset", END_T + 1, obs_d, D_RESET);
        applyStimulus(1'b1);
        checkOutput("small_restart", 0, obs_s, expectS(0));
        checkOutput("vga_restart", 0, obs_d, expectD(0));
        applyStimulus(1'b1);
        checkOutput("small_restart", 1, obs_s, expectS(1));
        checkOutput("vga_restart", 1, obs_d, expectD(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running 640×480 VGA raster timing generator for the demo top level. One pixel per clock. Produces the pixel coordinates consumed by the text and graphics overlay blocks, together with sync, blanking and per-frame animation outputs. The block drives everything the overlays read; the overlays never feed anything back to it.

## Interface

**Parameters**

- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, clocks
- `H_SYNC`, 96: hsync width, clocks
- `H_BP`, 48: horizontal back porch, clocks
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `SYNC_ACTIVE`, 1'b0: level of `hsync`/`vsync` when asserted (0 = negative polarity)

**Ports**

- `clk` in 1: pixel clock, 25.175 MHz nominal
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `x` out 10: horizontal position, 0..H_TOTAL-1
- `y` out 10: vertical position, 0..V_TOTAL-1. Overlays take `y[8:0]`, which is valid only while `display_on` is high.
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `display_on` out 1: high when `x`<H_ACTIVE and `y`<V_ACTIVE
- `line_start` out 1: one-clock pulse while `x`==0
- `frame_start` out 1: one-clock pulse while `x`==0 and `y`==0
- `frame_count` out 8: frame counter for animation; updated only during vertical blank

## Operation

- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
  - Both totals must be ≤1024. Elaboration fails if either exceeds 1024.
- State is two counters, `x` and `y`, plus `frame_count`. All outputs are registers. No combinational path exists from any input to any output.
- Every clock with `rst_n` high:
  - `x` increments.
  - When `x`==H_TOTAL-1, `x` wraps to 0 and `y` increments.
  - When `y`==V_TOTAL-1 at that same edge, `y` wraps to 0.
- Flag outputs are computed from the next-state (`x`,`y`) and registered in the same edge, so every flag describes the coordinate it is presented with.
- Sync windows:
  - `hsync`=SYNC_ACTIVE for H_ACTIVE+H_FP ≤ `x` < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~SYNC_ACTIVE.
  - `vsync`=SYNC_ACTIVE for V_ACTIVE+V_FP ≤ `y` < V_ACTIVE+V_FP+V_SYNC (490..491), over whole lines regardless of `x`.
- `frame_count` increments (mod 256) on the edge where (`x`,`y`) becomes (0, V_ACTIVE). The value therefore stays constant across every visible pixel of a frame.
- Reset state is the last blanking pixel: `x`=H_TOTAL-1 (799), `y`=V_TOTAL-1 (524).
  - `hsync`, `vsync` = ~SYNC_ACTIVE.
  - `display_on`, `line_start`, `frame_start` = 0.
  - `frame_count`=0.
  - This state is self-consistent: it is the real timing value for (799,524).
- Reset asserted mid-frame: all outputs return to the reset values at the next edge. No partial pulse is extended.

## Timing

- First edge with `rst_n` high gives `x`=0, `y`=0, `display_on`=1, `line_start`=1, `frame_start`=1, `frame_count`=0.
- Line period is 800 clocks.
- Frame period is 420 000 clocks.
- `frame_start` period is exactly 420 000 clocks. `line_start` period is exactly 800 clocks.
- `hsync` is asserted for 96 consecutive clocks. It starts at the clock presenting `x`=656.
- `vsync` is asserted for 1600 consecutive clocks. It starts at the clock presenting (0,490).
- `frame_count` changes exactly 384 000 clocks after each `frame_start`.
- Wrap-around at the end of a frame: (799,524) → (0,0). `y` increments only together with an `x` wrap, never otherwise.

## Structure

- Shared package `vga_timing_pkg` holds:
  - The eight default timing constants.
  - The derived H_TOTAL and V_TOTAL.
  - The sync window bounds.
- Overlay blocks import the same package for H_ACTIVE and V_ACTIVE.
- No sub-module. Both counters and the flag logic stay inline in one module of roughly 120–150 lines.

## Test plan

- Hold `rst_n` low for 5 clocks → `x`=799, `y`=524, `hsync`=`vsync`=1, `display_on`=0, `frame_count`=0.
- Release reset → first edge shows (0,0) with `frame_start`=`line_start`=`display_on`=1. The next `frame_start` arrives exactly 420 000 clocks later.
- Line 0 scan → `display_on` falls at `x`=640; `hsync` is low for `x`=656..751 (96 clocks); `line_start` repeats every 800 clocks.
- Full frame → `vsync` low only on lines 490–491 (1600 clocks); `display_on` never high for `y`≥480.
- Run 257 frames → `frame_count` steps at each (0,480), shows 0 during the first visible frame, and wraps 255→0.
- Assert `rst_n` at (300,200) for 1 clock → next edge shows the reset values; the following edge shows (0,0) with `frame_start`=1 and `frame_count`=0.
